// File: rtl/nav_pkg.sv
// Shared definitions for the rover navigation sequencer: state encoding,
// default location geometry and location field helpers.
package nav_pkg;

  localparam int unsigned R_W_DEF  = 8;
  localparam int unsigned TH_W_DEF = 4;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_RANGE1      = 4'd1,
    ST_SETTLE1     = 4'd2,
    ST_PROBE_TX    = 4'd3,
    ST_PROBE_WAIT  = 4'd4,
    ST_RANGE2      = 4'd5,
    ST_SETTLE2     = 4'd6,
    ST_ORIENT_HEAD = 4'd7,
    ST_ORIENT_TGT  = 4'd8,
    ST_PATH        = 4'd9,
    ST_CMD_TX      = 4'd10,
    ST_MOVE_WAIT   = 4'd11,
    ST_RANGE3      = 4'd12,
    ST_CHECK       = 4'd13
  } nav_state_e;

  // Radial (distance) field of a location or command, zero-extended.
  function automatic logic [31:0] loc_r(input logic [31:0] loc, input int unsigned r_w);
    return loc & ((32'd1 << r_w) - 32'd1);
  endfunction

  // Angle field of a location or command, zero-extended.
  function automatic logic [31:0] loc_th(input logic [31:0] loc, input int unsigned r_w,
                                         input int unsigned th_w);
    return (loc >> r_w) & ((32'd1 << th_w) - 32'd1);
  endfunction

endpackage

// File: rtl/nav_delay_timer.sv
// Loadable down-counter shared by all timed states; done_c marks the last
// cycle of a delay (a load of 0 or 1 both give a one-cycle delay).
module nav_delay_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_c = (cnt_q <= W'(1));

endmodule

// File: rtl/nav_sequencer.sv
// Rover navigation sequencer: ranges, probes heading with a fixed move, then
// iterates orient/path/move/check until the target is reached or retries run out.
module nav_sequencer
  import nav_pkg::*;
#(
  parameter int unsigned R_W              = R_W_DEF,
  parameter int unsigned TH_W             = TH_W_DEF,
  parameter int unsigned SETTLE_CYCLES    = 27000000,
  parameter int unsigned SEND_CYCLES      = 27000000,
  parameter int unsigned MOVE_UNIT_CYCLES = 27000000,
  parameter logic [R_W+TH_W-1:0] PROBE_CMD = 'h002,
  parameter int unsigned MAX_ITER         = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          abort,
  input  logic [R_W+TH_W-1:0]           target_location,
  input  logic [R_W+TH_W-1:0]           rover_location,
  output logic                          run_ultrasound,
  input  logic                          ultrasound_done,
  output logic                          orient_req,
  output logic [R_W+TH_W-1:0]           orient_from,
  output logic [R_W+TH_W-1:0]           orient_to,
  input  logic                          orient_done,
  input  logic [4:0]                    orient_result,
  output logic                          path_req,
  input  logic                          path_done,
  input  logic [R_W+TH_W-1:0]           path_cmd,
  output logic                          cmp_req,
  input  logic                          cmp_done,
  input  logic                          cmp_equal,
  output logic [R_W+TH_W-1:0]           move_command,
  output logic                          transmit_ir,
  output logic [4:0]                    orientation,
  output logic                          busy,
  output logic                          reached_target,
  output logic                          failed,
  output logic [$clog2(MAX_ITER+1)-1:0] iter_count,
  output logic [3:0]                    state
);

  localparam int unsigned L     = R_W + TH_W;
  localparam int unsigned IT_W  = $clog2(MAX_ITER + 1);
  localparam int unsigned FLD_W = (R_W > TH_W) ? R_W : TH_W;
  localparam int unsigned DLY_W = $clog2(MOVE_UNIT_CYCLES) + FLD_W + 1;
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned SND_W = $clog2(SEND_CYCLES + 1);
  localparam int unsigned TM1_W = (DLY_W > SET_W) ? DLY_W : SET_W;
  localparam int unsigned TMR_W = (TM1_W > SND_W) ? TM1_W : SND_W;

  nav_state_e state_q, state_d;
  logic [L-1:0]     loc_a_q, loc_a_d, loc_b_q, loc_b_d;
  logic [L-1:0]     from_q, from_d, to_q, to_d, cmd_q, cmd_d;
  logic [4:0]       orient_q, orient_d, bearing_q, bearing_d;
  logic [IT_W-1:0]  iter_q, iter_d;
  logic             reached_q, reached_d, failed_q, failed_d;
  logic             run_us_q, run_us_d, oreq_q, oreq_d, preq_q, preq_d, creq_q, creq_d;
  logic             tx_q, tx_d, busy_q, busy_d;
  logic             tmr_load, tmr_done;
  logic [TMR_W-1:0] tmr_val;

  // Travel time of a command: unit time times (distance + angle), never truncated.
  function automatic logic [TMR_W-1:0] move_delay(input logic [L-1:0] cmd);
    logic [31:0] units;
    units = loc_r(32'(cmd), R_W) + loc_th(32'(cmd), R_W, TH_W);
    return TMR_W'(MOVE_UNIT_CYCLES) * TMR_W'(units);
  endfunction

  nav_delay_timer #(.W(TMR_W)) u_timer (
    .clk      (clock),
    .rst_n    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done_c   (tmr_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      loc_a_q <= '0; loc_b_q <= '0; from_q <= '0; to_q <= '0; cmd_q <= '0;
      orient_q <= '0; bearing_q <= '0; iter_q <= '0;
      reached_q <= 1'b0; failed_q <= 1'b0;
      run_us_q <= 1'b0; oreq_q <= 1'b0; preq_q <= 1'b0; creq_q <= 1'b0;
      tx_q <= 1'b0; busy_q <= 1'b0;
    end else begin
      loc_a_q <= loc_a_d; loc_b_q <= loc_b_d; from_q <= from_d; to_q <= to_d; cmd_q <= cmd_d;
      orient_q <= orient_d; bearing_q <= bearing_d; iter_q <= iter_d;
      reached_q <= reached_d; failed_q <= failed_d;
      run_us_q <= run_us_d; oreq_q <= oreq_d; preq_q <= preq_d; creq_q <= creq_d;
      tx_q <= tx_d; busy_q <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    loc_a_d   = loc_a_q;
    loc_b_d   = loc_b_q;
    from_d    = from_q;
    to_d      = to_q;
    cmd_d     = cmd_q;
    orient_d  = orient_q;
    bearing_d = bearing_q;
    iter_d    = iter_q;
    reached_d = reached_q;
    failed_d  = failed_q;
    run_us_d  = 1'b0;
    oreq_d    = 1'b0;
    preq_d    = 1'b0;
    creq_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (enable) begin
          reached_d = 1'b0; failed_d = 1'b0; iter_d = '0;
          run_us_d = 1'b1; state_d = ST_RANGE1;
        end
        ST_RANGE1: if (ultrasound_done) begin
          tmr_load = 1'b1; tmr_val = TMR_W'(SETTLE_CYCLES); state_d = ST_SETTLE1;
        end
        ST_SETTLE1: if (tmr_done) begin
          loc_a_d = rover_location; cmd_d = PROBE_CMD;
          tmr_load = 1'b1; tmr_val = TMR_W'(SEND_CYCLES); state_d = ST_PROBE_TX;
        end
        ST_PROBE_TX: if (tmr_done) begin
          tmr_load = 1'b1; tmr_val = move_delay(cmd_q); state_d = ST_PROBE_WAIT;
        end
        ST_PROBE_WAIT: if (tmr_done) begin
          run_us_d = 1'b1; state_d = ST_RANGE2;
        end
        ST_RANGE2: if (ultrasound_done) begin
          tmr_load = 1'b1; tmr_val = TMR_W'(SETTLE_CYCLES); state_d = ST_SETTLE2;
        end
        // loc_a is already current here: set at SETTLE1 or shifted in CHECK.
        ST_SETTLE2: if (tmr_done) begin
          loc_b_d = rover_location; from_d = loc_a_q; to_d = rover_location;
          oreq_d = 1'b1; state_d = ST_ORIENT_HEAD;
        end
        ST_ORIENT_HEAD: if (orient_done) begin
          orient_d = orient_result; from_d = loc_b_q; to_d = target_location;
          oreq_d = 1'b1; state_d = ST_ORIENT_TGT;
        end
        ST_ORIENT_TGT: if (orient_done) begin
          bearing_d = orient_result; preq_d = 1'b1; state_d = ST_PATH;
        end
        ST_PATH: if (path_done) begin
          cmd_d = path_cmd; tmr_load = 1'b1; tmr_val = TMR_W'(SEND_CYCLES); state_d = ST_CMD_TX;
        end
        ST_CMD_TX: if (tmr_done) begin
          tmr_load = 1'b1; tmr_val = move_delay(cmd_q); state_d = ST_MOVE_WAIT;
        end
        ST_MOVE_WAIT: if (tmr_done) begin
          run_us_d = 1'b1; state_d = ST_RANGE3;
        end
        ST_RANGE3: if (ultrasound_done) begin
          creq_d = 1'b1; state_d = ST_CHECK;
        end
        ST_CHECK: if (cmp_done) begin
          if (cmp_equal) begin
            reached_d = 1'b1; state_d = ST_IDLE;
          end else if ((IT_W+1)'(iter_q) + (IT_W+1)'(1) == (IT_W+1)'(MAX_ITER)) begin
            failed_d = 1'b1; state_d = ST_IDLE;
          end else begin
            iter_d = iter_q + IT_W'(1); loc_a_d = loc_b_q;
            tmr_load = 1'b1; tmr_val = TMR_W'(SETTLE_CYCLES); state_d = ST_SETTLE2;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    tx_d   = (state_d == ST_PROBE_TX) || (state_d == ST_CMD_TX);
    busy_d = (state_d != ST_IDLE);
  end

  // The bearing feeds the path helper's context; it must be defined whenever PATH runs.
  assert property (@(posedge clock) disable iff (!reset)
                   (state_q == ST_PATH) |-> !$isunknown(bearing_q));

  assign run_ultrasound = run_us_q;
  assign orient_req     = oreq_q;
  assign orient_from    = from_q;
  assign orient_to      = to_q;
  assign path_req       = preq_q;
  assign cmp_req        = creq_q;
  assign move_command   = cmd_q;
  assign transmit_ir    = tx_q;
  assign orientation    = orient_q;
  assign busy           = busy_q;
  assign reached_target = reached_q;
  assign failed         = failed_q;
  assign iter_count     = iter_q;
  assign state          = state_q;

endmodule

// File: tb/tb_nav_sequencer.sv
// Directed bench for nav_sequencer with short timing parameters and
// helper responders modelled inline.
module tb_nav_sequencer;

  localparam int unsigned L = 12;

  logic         clock = 1'b0, reset = 1'b0, enable = 1'b0, abort = 1'b0;
  logic [L-1:0] target_location = 12'h345, rover_location = '0, path_cmd = '0;
  logic         ultrasound_done = 1'b0, orient_done = 1'b0, path_done = 1'b0;
  logic         cmp_done = 1'b0, cmp_equal = 1'b0;
  logic [4:0]   orient_result = 5'd9;
  logic         run_ultrasound, orient_req, path_req, cmp_req, transmit_ir;
  logic         busy, reached_target, failed;
  logic [L-1:0] orient_from, orient_to, move_command;
  logic [4:0]   orientation;
  logic [1:0]   iter_count;
  logic [3:0]   state;

  int n_vec = 0, n_bad = 0;
  int tx_cycles, tx_pulses, probe_wait_cycles, move_wait_cycles, settle1_cycles;
  int cmp_reqs, orient_n, us_n;
  bit tx_prev, cmp_eq_val, tmo;
  logic [L-1:0] path_val;
  logic [L-1:0] of_a [3];
  logic [L-1:0] ot_a [3];

  always #5 clock = ~clock;

  nav_sequencer #(
    .R_W(8), .TH_W(4), .SETTLE_CYCLES(4), .SEND_CYCLES(3), .MOVE_UNIT_CYCLES(2),
    .PROBE_CMD(12'h002), .MAX_ITER(3)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .abort(abort),
    .target_location(target_location), .rover_location(rover_location),
    .run_ultrasound(run_ultrasound), .ultrasound_done(ultrasound_done),
    .orient_req(orient_req), .orient_from(orient_from), .orient_to(orient_to),
    .orient_done(orient_done), .orient_result(orient_result),
    .path_req(path_req), .path_done(path_done), .path_cmd(path_cmd),
    .cmp_req(cmp_req), .cmp_done(cmp_done), .cmp_equal(cmp_equal),
    .move_command(move_command), .transmit_ir(transmit_ir), .orientation(orientation),
    .busy(busy), .reached_target(reached_target), .failed(failed),
    .iter_count(iter_count), .state(state)
  );

  task automatic clear_stats();
    tx_cycles = 0; tx_pulses = 0; probe_wait_cycles = 0; move_wait_cycles = 0;
    settle1_cycles = 0; cmp_reqs = 0; orient_n = 0; us_n = 0; tx_prev = 1'b0;
    for (int i = 0; i < 3; i++) begin of_a[i] = '0; ot_a[i] = '0; end
  endtask

  // Optionally start, then answer every request on the following cycle until
  // the given state is reached (stop_state >= 0) or the block goes idle.
  task automatic run_seq(input bit start, input int stop_state, input int budget,
                         output bit timeout);
    timeout = 1'b1;
    if (start) begin @(negedge clock); enable = 1'b1; end
    for (int n = 0; n < budget; n++) begin
      @(negedge clock);
      enable = 1'b0;
      ultrasound_done = 1'b0; orient_done = 1'b0; path_done = 1'b0; cmp_done = 1'b0;
      if (stop_state >= 0 && int'(state) == stop_state) begin timeout = 1'b0; break; end
      if (stop_state < 0 && !busy) begin timeout = 1'b0; break; end
      if (transmit_ir) begin tx_cycles++; if (!tx_prev) tx_pulses++; end
      tx_prev = transmit_ir;
      if (state == 4'd4)  probe_wait_cycles++;
      if (state == 4'd11) move_wait_cycles++;
      if (state == 4'd2)  settle1_cycles++;
      cmp_equal = cmp_eq_val;
      path_cmd  = path_val;
      if (run_ultrasound) begin
        us_n++; rover_location = 12'h100 + 12'(us_n); ultrasound_done = 1'b1;
      end
      if (orient_req) begin
        if (orient_n < 3) begin of_a[orient_n] = orient_from; ot_a[orient_n] = orient_to; end
        orient_n++; orient_done = 1'b1;
      end
      if (path_req) path_done = 1'b1;
      if (cmp_req) begin cmp_reqs++; cmp_done = 1'b1; end
    end
  endtask

  task automatic test_reset();
    #12;
    n_vec++; if (state !== 4'd0) begin n_bad++; $display("FAIL rst_state: got %0d expected 0", state); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_vec++; if (transmit_ir !== 1'b0) begin n_bad++; $display("FAIL rst_tx: got %b expected 0", transmit_ir); end
    n_vec++; if (move_command !== 12'h0) begin n_bad++; $display("FAIL rst_cmd: got %0h expected 0", move_command); end
    n_vec++; if ({reached_target, failed, iter_count} !== 4'b0) begin n_bad++;
      $display("FAIL rst_flags: got %b expected 0000", {reached_target, failed, iter_count}); end
    @(negedge clock); reset = 1'b1;
    repeat (3) @(negedge clock);
    n_vec++; if (state !== 4'd0) begin n_bad++; $display("FAIL rst_release_idle: got %0d expected 0", state); end
  endtask

  task automatic test_stray_done();
    @(negedge clock); ultrasound_done = 1'b1;
    @(negedge clock); ultrasound_done = 1'b0;
    n_vec++; if (state !== 4'd0) begin n_bad++; $display("FAIL stray_us_state: got %0d expected 0", state); end
    n_vec++; if (run_ultrasound !== 1'b0) begin n_bad++; $display("FAIL stray_us_req: got %b expected 0", run_ultrasound); end
    clear_stats(); cmp_eq_val = 1'b1; path_val = 12'h101;
    run_seq(1'b1, 7, 200, tmo);
    n_vec++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL stray_reach_head: got timeout %b expected 0", tmo); end
    path_done = 1'b1;
    @(negedge clock); path_done = 1'b0;
    n_vec++; if (state !== 4'd7) begin n_bad++; $display("FAIL stray_path_state: got %0d expected 7", state); end
    orient_done = 1'b1;
    @(negedge clock); orient_done = 1'b0;
    n_vec++; if (state !== 4'd8) begin n_bad++; $display("FAIL head_done_state: got %0d expected 8", state); end
    n_vec++; if (orientation !== 5'd9) begin n_bad++; $display("FAIL head_orient: got %0d expected 9", orientation); end
    abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    n_vec++; if (state !== 4'd0) begin n_bad++; $display("FAIL stray_abort_idle: got %0d expected 0", state); end
  endtask

  task automatic test_happy();
    clear_stats(); cmp_eq_val = 1'b1; path_val = 12'h101;
    run_seq(1'b1, -1, 400, tmo);
    n_vec++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL happy_timeout: got %b expected 0", tmo); end
    n_vec++; if (reached_target !== 1'b1) begin n_bad++; $display("FAIL happy_reached: got %b expected 1", reached_target); end
    n_vec++; if (failed !== 1'b0) begin n_bad++; $display("FAIL happy_failed: got %b expected 0", failed); end
    n_vec++; if (iter_count !== 2'd0) begin n_bad++; $display("FAIL happy_iter: got %0d expected 0", iter_count); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL happy_busy: got %b expected 0", busy); end
    n_vec++; if (tx_cycles !== 6) begin n_bad++; $display("FAIL happy_tx_cycles: got %0d expected 6", tx_cycles); end
    n_vec++; if (tx_pulses !== 2) begin n_bad++; $display("FAIL happy_tx_pulses: got %0d expected 2", tx_pulses); end
    n_vec++; if (probe_wait_cycles !== 4) begin n_bad++; $display("FAIL probe_wait: got %0d expected 4", probe_wait_cycles); end
    n_vec++; if (settle1_cycles !== 4) begin n_bad++; $display("FAIL settle1: got %0d expected 4", settle1_cycles); end
    n_vec++; if (move_wait_cycles !== 4) begin n_bad++; $display("FAIL happy_move_wait: got %0d expected 4", move_wait_cycles); end
    n_vec++; if (move_command !== 12'h101) begin n_bad++; $display("FAIL happy_cmd: got %0h expected 101", move_command); end
    n_vec++; if (orientation !== 5'd9) begin n_bad++; $display("FAIL happy_orient: got %0d expected 9", orientation); end
    n_vec++; if ({of_a[0], ot_a[0]} !== {12'h101, 12'h102}) begin n_bad++;
      $display("FAIL head_operands: got %0h/%0h expected 101/102", of_a[0], ot_a[0]); end
    n_vec++; if ({of_a[1], ot_a[1]} !== {12'h102, 12'h345}) begin n_bad++;
      $display("FAIL tgt_operands: got %0h/%0h expected 102/345", of_a[1], ot_a[1]); end
    n_vec++; if (cmp_reqs !== 1) begin n_bad++; $display("FAIL happy_cmp_reqs: got %0d expected 1", cmp_reqs); end
  endtask

  task automatic test_retry();
    clear_stats(); cmp_eq_val = 1'b0; path_val = 12'h000;
    run_seq(1'b1, -1, 600, tmo);
    n_vec++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL retry_timeout: got %b expected 0", tmo); end
    n_vec++; if (failed !== 1'b1) begin n_bad++; $display("FAIL retry_failed: got %b expected 1", failed); end
    n_vec++; if (reached_target !== 1'b0) begin n_bad++; $display("FAIL retry_reached: got %b expected 0", reached_target); end
    n_vec++; if (iter_count !== 2'd2) begin n_bad++; $display("FAIL retry_iter: got %0d expected 2", iter_count); end
    n_vec++; if (cmp_reqs !== 3) begin n_bad++; $display("FAIL retry_checks: got %0d expected 3", cmp_reqs); end
    n_vec++; if (move_wait_cycles !== 3) begin n_bad++; $display("FAIL zero_move_wait: got %0d expected 3", move_wait_cycles); end
    n_vec++; if (tx_cycles !== 12) begin n_bad++; $display("FAIL retry_tx_cycles: got %0d expected 12", tx_cycles); end
    n_vec++; if ({of_a[2], ot_a[2]} !== {12'h102, 12'h103}) begin n_bad++;
      $display("FAIL retry_operands: got %0h/%0h expected 102/103", of_a[2], ot_a[2]); end
  endtask

  task automatic test_abort();
    clear_stats(); cmp_eq_val = 1'b1; path_val = 12'h101;
    run_seq(1'b1, 10, 300, tmo);
    n_vec++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL abort_reach_tx: got timeout %b expected 0", tmo); end
    n_vec++; if (transmit_ir !== 1'b1) begin n_bad++; $display("FAIL abort_pre_tx: got %b expected 1", transmit_ir); end
    abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    n_vec++; if (state !== 4'd0) begin n_bad++; $display("FAIL abort_state: got %0d expected 0", state); end
    n_vec++; if (transmit_ir !== 1'b0) begin n_bad++; $display("FAIL abort_tx: got %b expected 0", transmit_ir); end
    n_vec++; if ({busy, reached_target, failed} !== 3'b000) begin n_bad++;
      $display("FAIL abort_flags: got %b expected 000", {busy, reached_target, failed}); end
  endtask

  task automatic test_reset_mid();
    clear_stats(); cmp_eq_val = 1'b1; path_val = 12'h101;
    run_seq(1'b1, 11, 300, tmo);
    n_vec++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL rmid_reach_wait: got timeout %b expected 0", tmo); end
    #2 reset = 1'b0;
    #1;
    n_vec++; if (state !== 4'd0) begin n_bad++; $display("FAIL rmid_state: got %0d expected 0", state); end
    n_vec++; if ({busy, transmit_ir, run_ultrasound} !== 3'b000) begin n_bad++;
      $display("FAIL rmid_ctrl: got %b expected 000", {busy, transmit_ir, run_ultrasound}); end
    n_vec++; if ({move_command, orient_from, orient_to} !== 36'h0) begin n_bad++;
      $display("FAIL rmid_buses: got %0h expected 0", {move_command, orient_from, orient_to}); end
    n_vec++; if (orientation !== 5'd0) begin n_bad++; $display("FAIL rmid_orient: got %0d expected 0", orientation); end
    @(negedge clock); reset = 1'b1;
    repeat (4) @(negedge clock);
    n_vec++; if ({state, busy} !== 5'b0) begin n_bad++;
      $display("FAIL rmid_wait_idle: got %b expected 00000", {state, busy}); end
  endtask

  initial begin
    test_reset();
    test_stray_done();
    test_happy();
    test_retry();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
